// File: rtl/ap_ctrl_pkg.sv
// Shared types and defaults for the ap_ctrl_chain initiator (driver FSM states, widths, helpers).
package ap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_e;

    localparam int CYC_W       = 32;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MAX_OUT = 4;
    localparam int DEF_TIMEOUT = 4096;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ap_ctrl_watchdog.sv
// Progress watchdog: counts enabled cycles since the last clear and flags expiry on the TIMEOUT-th one.
module ap_ctrl_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q, count_d;

    // A clear in the same cycle as the would-be last count wins, so real progress never trips it.
    always_comb begin
        count_d = count_q;
        expired = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == W'(TIMEOUT - 1)) begin
                expired = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ap_ctrl_chain_driver.sv
// Initiator side of the ap_ctrl_chain handshake: issues a programmed number of starts and acknowledges dones.
// Build option AP_CTRL_CONT_STALL_EN: ap_continue is held low for cfg_stall cycles after each handshake.
module ap_ctrl_chain_driver
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] cfg_num_trans,
    input  logic [7:0]       cfg_stall,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             err_proto,
    output logic             err_timeout
);

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             ap_start_q, ap_start_d;
    logic             ap_cont_q, ap_cont_d;
    logic             err_proto_q, err_proto_d;
    logic             err_timeout_q, err_timeout_d;

    logic active, go_take, accept, handshake, none_outstanding, wd_expired, cont_hold;

    assign active           = (state_q == RUN) || (state_q == DRAIN);
    assign go_take          = go && ((state_q == IDLE) || (state_q == FINISH));
    assign accept           = ap_start_q && ap_ready;
    assign handshake        = ap_done && ap_cont_q;
    assign none_outstanding = (issued_q == done_q);

    ap_ctrl_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (go_take || accept || handshake),
        .enable (active),
        .expired(wd_expired)
    );

`ifdef AP_CTRL_CONT_STALL_EN
    logic [7:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (go_take) begin
            stall_d = '0;
        end else if (active) begin
            if (handshake) begin
                stall_d = cfg_stall;
            end else if (stall_q != '0) begin
                stall_d = stall_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign cont_hold = (stall_d != '0);
`else
    logic unused_cfg_stall;
    assign unused_cfg_stall = ^cfg_stall;
    assign cont_hold        = 1'b0;
`endif

    // ap_start/ap_continue are computed from next-state values so both stay registered outputs.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        issued_d      = issued_q;
        done_d        = done_q;
        cyc_d         = cyc_q;
        err_proto_d   = err_proto_q;
        err_timeout_d = err_timeout_q;

        if (go_take) begin
            num_d         = cfg_num_trans;
            issued_d      = '0;
            done_d        = '0;
            cyc_d         = '0;
            err_proto_d   = 1'b0;
            err_timeout_d = 1'b0;
            state_d       = (cfg_num_trans == '0) ? FINISH : RUN;
        end else if (active) begin
            cyc_d = sat_inc(cyc_q);
            if (accept) begin
                issued_d = issued_q + 1'b1;
            end
            if (handshake) begin
                if (none_outstanding) begin
                    err_proto_d = 1'b1;
                end else begin
                    done_d = done_q + 1'b1;
                end
            end
            if (wd_expired) begin
                err_timeout_d = 1'b1;
                state_d       = FINISH;
            end else if (done_d == num_q) begin
                state_d = FINISH;
            end else if (issued_d == num_q) begin
                state_d = DRAIN;
            end
        end

        ap_start_d = (state_d == RUN) && (issued_d < num_d) &&
                     ((issued_d - done_d) < MAX_OUT_C);
        ap_cont_d  = ((state_d == RUN) || (state_d == DRAIN)) && !cont_hold;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            num_q         <= '0;
            issued_q      <= '0;
            done_q        <= '0;
            cyc_q         <= '0;
            ap_start_q    <= 1'b0;
            ap_cont_q     <= 1'b0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            issued_q      <= issued_d;
            done_q        <= done_d;
            cyc_q         <= cyc_d;
            ap_start_q    <= ap_start_d;
            ap_cont_q     <= ap_cont_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign ap_start    = ap_start_q;
    assign ap_continue = ap_cont_q;
    assign busy        = active;
    assign finish      = (state_q == FINISH);
    assign issued_cnt  = issued_q;
    assign done_cnt    = done_q;
    assign cycle_cnt   = cyc_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Randomized bench for ap_ctrl_chain_driver with an emulated HLS block and a transaction-level reference model.
// Honours AP_CTRL_CONT_STALL_EN the same way the design does.
module tb_ap_ctrl_chain_driver;

    localparam int CNT_W   = 16;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 16;
`ifdef AP_CTRL_CONT_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             go = 1'b0;
    logic [CNT_W-1:0] cfg_num_trans = '0;
    logic [7:0]       cfg_stall = '0;
    logic             ap_start, ap_continue, busy, finish, err_proto, err_timeout;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic [CNT_W-1:0] issued_cnt, done_cnt;
    logic [31:0]      cycle_cnt;

    always #5 clock = ~clock;

    ap_ctrl_chain_driver #(
        .CNT_W  (CNT_W),
        .MAX_OUT(MAX_OUT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .cfg_num_trans(cfg_num_trans),
        .cfg_stall    (cfg_stall),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .finish       (finish),
        .issued_cnt   (issued_cnt),
        .done_cnt     (done_cnt),
        .cycle_cnt    (cycle_cnt),
        .err_proto    (err_proto),
        .err_timeout  (err_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Emulated HLS block: accepted starts become dones after a random latency, oldest first.
    int unsigned ready_pct  = 100;
    int unsigned lat_lo     = 1;
    int unsigned lat_hi     = 1;
    bit          hold_done  = 1'b0;
    bit          force_done = 1'b0;
    logic [7:0]  stall_cfg  = '0;
    int          cyc_now    = 0;
    int          pend[$];

    // Reference model in terms of a run: counts of starts/dones, idle time, pending stall.
    bit     m_busy, m_fin, m_ep, m_et, m_start, m_cont;
    int     m_n, m_iss, m_done, m_wd, m_stall;
    longint m_cyc;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc_now);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_step(input bit go_i, input int n_i, input bit rdy,
                                       input bit done_i, input bit rst_i, input int stall_i);
        bit acc, hs;
        if (rst_i) begin
            m_busy = 0; m_fin = 0; m_ep = 0; m_et = 0;
            m_n = 0; m_iss = 0; m_done = 0; m_wd = 0; m_stall = 0; m_cyc = 0;
        end else if (!m_busy && go_i) begin
            m_n = n_i; m_iss = 0; m_done = 0; m_wd = 0; m_stall = 0; m_cyc = 0;
            m_ep = 0; m_et = 0;
            m_busy = (n_i != 0);
            m_fin  = (n_i == 0);
        end else if (m_busy) begin
            acc = m_start && rdy;
            hs  = done_i && m_cont;
            if (hs && m_iss == m_done) m_ep = 1;
            else if (hs) m_done++;
            if (acc) m_iss++;
            m_cyc = (m_cyc == 64'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
            m_wd  = (acc || hs) ? 0 : m_wd + 1;
            if (STALL_EN) m_stall = hs ? stall_i : ((m_stall > 0) ? m_stall - 1 : 0);
            if (m_wd == TIMEOUT) begin
                m_et = 1; m_busy = 0; m_fin = 1;
            end else if (m_done == m_n) begin
                m_busy = 0; m_fin = 1;
            end
        end
        m_start = m_busy && (m_iss < m_n) && (m_iss - m_done < MAX_OUT);
        m_cont  = m_busy && (m_stall == 0);
    endfunction

    // One clock cycle: drive inputs, advance model and emulator, then compare every output.
    task automatic applyStimulus(input bit go_i, input int n_i, input bit rst_i);
        reset         = rst_i;
        go            = go_i;
        cfg_num_trans = CNT_W'(n_i);
        cfg_stall     = stall_cfg;
        ap_ready      = ($urandom_range(99) < ready_pct);
        ap_done       = force_done || (!hold_done && pend.size() > 0 && pend[0] <= cyc_now);
        model_step(go_i, n_i, ap_ready, ap_done, rst_i, int'(stall_cfg));
        if (rst_i || (go_i && !busy)) begin
            pend.delete();
        end else begin
            if (ap_start && ap_ready) pend.push_back(cyc_now + int'($urandom_range(lat_hi, lat_lo)));
            if (ap_done && ap_continue && pend.size() > 0) void'(pend.pop_front());
        end
        @(posedge clock);
        @(negedge clock);
        cyc_now++;
        checkOutput("ap_start", ap_start, m_start);
        checkOutput("ap_continue", ap_continue, m_cont);
        checkOutput("busy", busy, m_busy);
        checkOutput("finish", finish, m_fin);
        checkOutput("issued_cnt", issued_cnt, m_iss);
        checkOutput("done_cnt", done_cnt, m_done);
        checkOutput("cycle_cnt", cycle_cnt, m_cyc);
        checkOutput("err_proto", err_proto, m_ep);
        checkOutput("err_timeout", err_timeout, m_et);
    endtask

    task automatic run_to_end(input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            applyStimulus(1'b0, 0, 1'b0);
            k++;
        end
        checkOutput("run_bound", busy, 0);
    endtask

    initial begin
        int k, lows, rst_at;

        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("rst_finish", finish, 0);
        checkOutput("rst_issued", issued_cnt, 0);
        applyStimulus(1'b0, 0, 1'b0);

        // N=3, immediate ready, done two cycles after each accept
        ready_pct = 100; lat_lo = 2; lat_hi = 2;
        applyStimulus(1'b1, 3, 1'b0);
        run_to_end(60);
        checkOutput("t1_issued", issued_cnt, 3);
        checkOutput("t1_done", done_cnt, 3);
        checkOutput("t1_finish", finish, 1);
        checkOutput("t1_errs", {err_proto, err_timeout}, 0);

        // N=0 goes straight to FINISH with nothing issued
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("t2_finish", finish, 1);
        checkOutput("t2_start", ap_start, 0);
        checkOutput("t2_cycles", cycle_cnt, 0);
        applyStimulus(1'b0, 0, 1'b0);

        // Outstanding limit: dones withheld, starts must stop at MAX_OUT
        lat_lo = 1; lat_hi = 1; hold_done = 1;
        applyStimulus(1'b1, 8, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t3_issued_cap", issued_cnt, 4);
        checkOutput("t3_start_low", ap_start, 0);
        hold_done = 0;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t3_resume", ap_start, 1);
        run_to_end(80);
        checkOutput("t3_done", done_cnt, 8);

        // Done with nothing outstanding
        ready_pct = 0;
        applyStimulus(1'b1, 2, 1'b0);
        force_done = 1;
        applyStimulus(1'b0, 0, 1'b0);
        force_done = 0;
        checkOutput("t4_err_proto", err_proto, 1);
        checkOutput("t4_done", done_cnt, 0);
        ready_pct = 100;
        run_to_end(60);
        checkOutput("t4_sticky", err_proto, 1);

        // Watchdog: ready never comes
        ready_pct = 0;
        applyStimulus(1'b1, 5, 1'b0);
        k = 0;
        while (busy && k < 40) begin
            applyStimulus(1'b0, 0, 1'b0);
            k++;
        end
        checkOutput("t5_run_cycles", k, TIMEOUT);
        checkOutput("t5_err_timeout", err_timeout, 1);
        checkOutput("t5_finish", finish, 1);
        checkOutput("t5_issued", issued_cnt, 0);
        checkOutput("t5_cycles", cycle_cnt, TIMEOUT);

        // Continue stall, then reset in the middle of the run
        ready_pct = 100; lat_lo = 1; lat_hi = 1; stall_cfg = 8'd3;
        applyStimulus(1'b1, 4, 1'b0);
        k = 0;
        while (done_cnt < 1 && k < 40) begin
            applyStimulus(1'b0, 0, 1'b0);
            k++;
        end
        checkOutput("t6_first_done", done_cnt, 1);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            if (ap_continue) break;
            lows++;
            applyStimulus(1'b0, 0, 1'b0);
        end
        checkOutput("t6_stall_len", lows, STALL_EN ? 3 : 0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t6_rst_outputs",
                    {ap_start, ap_continue, busy, finish, err_proto, err_timeout}, 0);
        checkOutput("t6_rst_counts", {issued_cnt, done_cnt, cycle_cnt}, 0);
        applyStimulus(1'b0, 0, 1'b0);

        // Randomized runs with stray go pulses and occasional resets
        for (int r = 0; r < 30; r++) begin
            ready_pct = $urandom_range(100, 40);
            lat_lo    = 0;
            lat_hi    = $urandom_range(5, 0);
            stall_cfg = 8'($urandom_range(3, 0));
            rst_at    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 2)) : -1;
            applyStimulus(1'b1, int'($urandom_range(10, 0)), 1'b0);
            k = 0;
            while (busy && k < 200) begin
                applyStimulus($urandom_range(9, 0) == 0, int'($urandom_range(15, 0)), k == rst_at);
                k++;
            end
            checkOutput("rand_bound", busy, 0);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
